// File: rtl/rtl_kernel_wizard_0_example_checker_pkg.sv
// Shared types and helpers for the example number checker: FSM state
// encoding, backpressure LFSR constants and the expected-tkeep function.
package rtl_kernel_wizard_0_example_checker_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  // 16-bit maximal-length Fibonacci LFSR, taps 16,15,13,4 (bits 15,14,12,3)
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hD008;

  // Widest tkeep the helper can describe (1024-bit stream)
  localparam int MAX_KEEP_W = 128;

  // Expected byte enables for a beat: all ones, except a partial last beat
  // whose low (len % bytes) bytes are enabled.
  function automatic logic [MAX_KEEP_W-1:0] exp_keep(input int unsigned len,
                                                     input int unsigned bytes,
                                                     input logic last);
    int unsigned rem;
    int unsigned lim;
    logic [MAX_KEEP_W-1:0] k;
    rem = len % bytes;
    lim = (last && rem != 0) ? rem : bytes;
    for (int unsigned i = 0; i < MAX_KEEP_W; i++) k[i] = (i < lim);
    return k;
  endfunction

endpackage

// File: rtl/rtl_kernel_wizard_0_example_lane_checker.sv
// One number lane of the checker: regenerates {beat, lane} and compares it
// with the received lane, masking out bytes the expected tkeep disables.
module rtl_kernel_wizard_0_example_lane_checker #(
  parameter int NBW  = 32,
  parameter int SB   = 2,
  parameter int LANE = 0
) (
  input  logic [NBW-1:0]   lane_data,
  input  logic [NBW/8-1:0] lane_keep,
  input  logic [31:0]      beat,
  output logic             mismatch
);

  logic [NBW-1:0] expected;
  logic [NBW-1:0] mask;

  // Expected value wraps with the NBW-wide field; lane index fills the low SB bits
  always_comb begin
    expected = (NBW'(beat) << SB) | NBW'(LANE);
    mask     = '0;
    for (int i = 0; i < NBW / 8; i++) mask[i*8 +: 8] = {8{lane_keep[i]}};
    mismatch = |((lane_data ^ expected) & mask);
  end

endmodule

// File: rtl/rtl_kernel_wizard_0_example_number_checker.sv
// AXI4-Stream checker for the example incrementing-number stream.
// Checks data (byte-masked), tkeep and tlast per beat, accumulates errors and
// pulses ap_done when a transfer ends.
// Optional: define RTL_KERNEL_WIZARD_0_NUMBER_CHECKER_BACKPRESSURE_EN to
// throttle tready in RUN with an LFSR (about 75% duty).
module rtl_kernel_wizard_0_example_number_checker
  import rtl_kernel_wizard_0_example_checker_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = 128,
  parameter int C_NUMBER_BIT_WIDTH   = 32,
  parameter int C_LENGTH_IN_BYTES    = 16384
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic                              ap_start,
  output logic                              ap_done,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                              s_axis_tlast,
  output logic                              error,
  output logic [31:0]                       error_count,
  output logic [31:0]                       first_err_beat
);

  localparam int NBW = (C_NUMBER_BIT_WIDTH < C_S_AXIS_TDATA_WIDTH) ?
                       C_NUMBER_BIT_WIDTH : C_S_AXIS_TDATA_WIDTH;
  localparam int LANES     = C_S_AXIS_TDATA_WIDTH / NBW;
  localparam int SB        = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int BYTES     = C_S_AXIS_TDATA_WIDTH / 8;
  localparam int NUM_BEATS = (C_LENGTH_IN_BYTES + BYTES - 1) / BYTES;
  localparam logic [31:0] LAST_BEAT = 32'(NUM_BEATS - 1);

  state_t           state;
  logic             ap_start_r;
  logic [31:0]      beat;
  logic             go;
  logic             accept;
  logic             is_last;
  logic             beat_err;
  logic [LANES-1:0] lane_mm;
  logic [BYTES-1:0] exp_tkeep;

  assign go        = ap_start & ~ap_start_r;
  assign accept    = s_axis_tvalid & s_axis_tready;
  assign is_last   = (beat == LAST_BEAT);
  assign exp_tkeep = BYTES'(exp_keep(C_LENGTH_IN_BYTES, BYTES, is_last));
  assign beat_err  = (|lane_mm) | (s_axis_tkeep != exp_tkeep) | (s_axis_tlast != is_last);

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    rtl_kernel_wizard_0_example_lane_checker #(
      .NBW (NBW),
      .SB  (SB),
      .LANE(n)
    ) u_lane (
      .lane_data(s_axis_tdata[n*NBW +: NBW]),
      .lane_keep(exp_tkeep[n*(NBW/8) +: NBW/8]),
      .beat     (beat),
      .mismatch (lane_mm[n])
    );
  end

`ifdef RTL_KERNEL_WIZARD_0_NUMBER_CHECKER_BACKPRESSURE_EN
  logic [15:0] lfsr;

  // Free-running LFSR, reseeded on reset and on every go
  always_ff @(posedge aclk) begin
    if (areset || go) lfsr <= LFSR_SEED;
    else              lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  assign s_axis_tready = (state == S_RUN) & (lfsr[0] | lfsr[1]);
`else
  assign s_axis_tready = (state == S_RUN);
`endif

  // Transfer FSM, beat counter and error accumulators
  always_ff @(posedge aclk) begin
    if (areset) begin
      state          <= S_IDLE;
      ap_start_r     <= 1'b0;
      ap_done        <= 1'b0;
      beat           <= '0;
      error          <= 1'b0;
      error_count    <= '0;
      first_err_beat <= '1;
    end else begin
      ap_start_r <= ap_start;
      ap_done    <= 1'b0;
      if (go && state != S_DONE) begin
        // go in IDLE starts, go in RUN restarts from beat 0
        state          <= S_RUN;
        beat           <= '0;
        error          <= 1'b0;
        error_count    <= '0;
        first_err_beat <= '1;
      end else begin
        case (state)
          S_RUN: begin
            if (accept) begin
              if (beat_err) begin
                error <= 1'b1;
                if (error_count != '1) error_count <= error_count + 32'd1;
                if (!error) first_err_beat <= beat;
              end
              if (s_axis_tlast || is_last) begin
                state   <= S_DONE;
                ap_done <= 1'b1;
              end else begin
                beat <= beat + 32'd1;
              end
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
